// File: rtl/uart_bridge_pkg.sv
// Shared sizing and state types for the UART block bridge (RX assembler + TX serializer).
package uart_bridge_pkg;
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = BLOCK_BYTES * 8;
    localparam int IDX_W       = $clog2(BLOCK_BYTES);

    typedef enum logic {
        RX_COLLECT,
        RX_HOLD
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_e;
endpackage

// File: rtl/uart_block_ser.sv
// Serializes a 16-byte block into one tx_start per byte, MSB byte first; never starts while tx_busy.
// Latency: first tx_start the cycle after acceptance at the earliest; blk_in_ready only in IDLE.
module uart_block_ser
    import uart_bridge_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic               blk_in_valid,
    output logic               blk_in_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy
);
    tx_state_e          state_q, state_d;
    logic [BLOCK_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    // The byte being sent always sits in the top lane, so tx_data is stable until it is shifted out.
    assign tx_data = shreg_q[BLOCK_W-1 -: 8];

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        tx_start     = 1'b0;
        blk_in_ready = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                blk_in_ready = ~rst;
                if (blk_in_valid && !rst) begin
                    shreg_d = blk_in;
                    idx_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (!tx_busy && !rst) begin
                    tx_start = 1'b1;
                    state_d  = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (tx_busy) state_d = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    shreg_d = {shreg_q[BLOCK_W-9:0], 8'h00};
                    if (idx_q == IDX_W'(BLOCK_BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = TX_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = TX_START;
                    end
                end
            end
        endcase
    end
endmodule

// File: rtl/uart_block_bridge.sv
// Bridges UART bytes to 128-bit blocks both ways; RX assembles 16 bytes and holds until consumed.
// Optional macro UART_BRIDGE_TIMEOUT_EN discards a stalled partial RX block after TIMEOUT_CLKS idle cycles.
module uart_block_bridge
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 4340
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [BLOCK_W-1:0] blk_out,
    output logic               blk_out_valid,
    input  logic               blk_out_ready,
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic               blk_in_valid,
    output logic               blk_in_ready,
    output logic               rx_overrun,
    output logic               rx_timeout
);
    if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be at least 2");
    end

    rx_state_e          rx_state_q, rx_state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic               ovr_q, ovr_d;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CLKS) + 1;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              tmo_q, tmo_d;
    assign rx_timeout = tmo_q;
`else
    assign rx_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_COLLECT;
            cnt_q      <= '0;
            blk_q      <= '0;
            ovr_q      <= 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            idle_q     <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            ovr_q      <= ovr_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
            idle_q     <= idle_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        blk_d      = blk_q;
        ovr_d      = 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
        idle_d     = idle_q;
        tmo_d      = 1'b0;
`endif
        unique case (rx_state_q)
            RX_COLLECT: begin
                // Shifting left leaves the first byte of the block in the top lane after 16 bytes.
                if (rx_valid) begin
                    blk_d = {blk_q[BLOCK_W-9:0], rx_data};
                    if (cnt_q == IDX_W'(BLOCK_BYTES - 1)) begin
                        cnt_d      = '0;
                        rx_state_d = RX_HOLD;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
`ifdef UART_BRIDGE_TIMEOUT_EN
                    idle_d = '0;
                end else if (cnt_q != '0) begin
                    if (idle_q == IDLE_W'(TIMEOUT_CLKS - 1)) begin
                        idle_d = '0;
                        cnt_d  = '0;
                        tmo_d  = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
`endif
                end
            end
            RX_HOLD: begin
                ovr_d = rx_valid;
                if (blk_out_ready) rx_state_d = RX_COLLECT;
            end
        endcase
    end

    assign blk_out       = blk_q;
    assign blk_out_valid = (rx_state_q == RX_HOLD);
    assign rx_overrun    = ovr_q;

    uart_block_ser u_ser (
        .clk          (clk),
        .rst          (rst),
        .blk_in       (blk_in),
        .blk_in_valid (blk_in_valid),
        .blk_in_ready (blk_in_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy)
    );
endmodule

// File: tb/tb_uart_block_bridge.sv
// Self-checking bench for uart_block_bridge: vector table for RX blocks, hand sequences, randomized RX/TX vs queue model.
`timescale 1ns/1ps
module tb_uart_block_bridge;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy;
    logic [127:0] blk_out;
    logic         blk_out_valid;
    logic         blk_out_ready;
    logic [127:0] blk_in;
    logic         blk_in_valid;
    logic         blk_in_ready;
    logic         rx_overrun;
    logic         rx_timeout;

    logic bm_busy, busy_hold;
    assign tx_busy = bm_busy | busy_hold;

    int n_chk = 0, n_fail = 0;
    int start_cnt = 0, ovr_cnt = 0, tmo_cnt = 0;
    int bm_len;
    bit busy_rand = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_block_bridge #(.TIMEOUT_CLKS(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .blk_out(blk_out), .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
        .blk_in(blk_in), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready),
        .rx_overrun(rx_overrun), .rx_timeout(rx_timeout)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse counters and tx byte capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_overrun) ovr_cnt++;
        if (rx_timeout) tmo_cnt++;
        if (tx_start) begin
            start_cnt++;
            got_q.push_back(tx_data);
            chk("tx_start_while_busy", {127'd0, tx_busy}, 128'd0);
        end
    end

    // UART transmitter model: busy from the cycle after an accepted tx_start.
    initial begin
        bm_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                bm_len = busy_rand ? int'($urandom_range(1, 12)) : 10;
                @(posedge clk);
                #1 bm_busy = 1'b1;
                repeat (bm_len) @(posedge clk);
                #1 bm_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        repeat ($urandom_range(0, max_gap)) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] base, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) send_byte(base + 8'(int'(step) * i), 2);
    endtask

    task automatic wait_blk(input string name, input logic [127:0] exp);
        for (int i = 0; i < 20 && !blk_out_valid; i++) tick();
        chk({name, "_valid"}, {127'd0, blk_out_valid}, 128'd1);
        chk({name, "_data"}, blk_out, exp);
    endtask

    task automatic release_blk(input string name);
        blk_out_ready = 1'b1;
        tick();
        blk_out_ready = 1'b0;
        chk({name, "_released"}, {127'd0, blk_out_valid}, 128'd0);
    endtask

    task automatic offer_tx(input logic [127:0] b);
        for (int i = 0; i < 2000 && !blk_in_ready; i++) tick();
        for (int i = 0; i < 16; i++) exp_q.push_back(b[127-8*i -: 8]);
        blk_in       = b;
        blk_in_valid = 1'b1;
        tick();
        blk_in_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input string name);
        for (int i = 0; i < 2000 && !blk_in_ready; i++) tick();
        chk({name, "_ready_back"}, {127'd0, blk_in_ready}, 128'd1);
        tick();
        chk({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, "_byte"}, {120'd0, got_q[i]}, {120'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0]   base;
        logic [7:0]   step;
        int           extra;
        bit           rdy;
        logic [127:0] exp_blk;
    } rx_vec_t;

    rx_vec_t vt[3];

    initial begin
        int s0, o0, m_ovr;
        bit m_hold;
        logic [7:0]   m_q[$];
        logic [127:0] m_blk;

        vt[0] = '{8'h00, 8'h01, 0, 1'b1, 128'h000102030405060708090A0B0C0D0E0F};
        vt[1] = '{8'h10, 8'h11, 1, 1'b0, 128'h102132435465768798A9BACBDCEDFE0F};
        vt[2] = '{8'hFF, 8'hFF, 3, 1'b0, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0};

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; blk_out_ready = 1'b0;
        blk_in = '0; blk_in_valid = 1'b0; busy_hold = 1'b0;
        tick();
        chk("rst_blk_in_ready", {127'd0, blk_in_ready}, 128'd0);
        chk("rst_blk_out", blk_out, 128'd0);
        chk("rst_blk_out_valid", {127'd0, blk_out_valid}, 128'd0);
        chk("rst_tx_start", {127'd0, tx_start}, 128'd0);
        chk("rst_tx_data", {120'd0, tx_data}, 128'd0);
        chk("rst_overrun", {127'd0, rx_overrun}, 128'd0);
        chk("rst_timeout", {127'd0, rx_timeout}, 128'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_blk_in_ready", {127'd0, blk_in_ready}, 128'd1);

        // Table: fill a block, optionally pile extra bytes onto a held block.
        for (int v = 0; v < 3; v++) begin
            blk_out_ready = vt[v].rdy;
            send_seq(vt[v].base, vt[v].step, 16);
            wait_blk("tbl_blk", vt[v].exp_blk);
            if (vt[v].rdy) begin
                tick();
                chk("tbl_valid_one_cycle", {127'd0, blk_out_valid}, 128'd0);
                blk_out_ready = 1'b0;
            end else begin
                o0 = ovr_cnt;
                for (int e = 0; e < vt[v].extra; e++) send_byte(8'hAA, 2);
                tick();
                tick();
                chk("tbl_overrun_count", 128'(ovr_cnt - o0), 128'(vt[v].extra));
                chk("tbl_blk_stable", blk_out, vt[v].exp_blk);
                release_blk("tbl");
            end
        end

        // Byte arriving in the release cycle is dropped, next block is clean.
        send_seq(8'h20, 8'h01, 16);
        wait_blk("drop_first", 128'h202122232425262728292A2B2C2D2E2F);
        o0 = ovr_cnt;
        rx_data = 8'h55; rx_valid = 1'b1; blk_out_ready = 1'b1;
        tick();
        rx_valid = 1'b0; blk_out_ready = 1'b0;
        chk("drop_released", {127'd0, blk_out_valid}, 128'd0);
        tick();
        chk("drop_overrun", 128'(ovr_cnt - o0), 128'd1);
        send_seq(8'h30, 8'h01, 16);
        wait_blk("drop_next", 128'h303132333435363738393A3B3C3D3E3F);
        release_blk("drop");

        // Fixed 10-cycle busy per byte.
        got_q.delete(); exp_q.delete();
        offer_tx(128'h00112233445566778899AABBCCDDEEFF);
        wait_tx_done("tx_basic");

        // Transmitter already busy at acceptance.
        busy_hold = 1'b1;
        s0 = start_cnt;
        offer_tx(128'hDEADBEEF0123456789ABCDEF5A5AA5A5);
        repeat (20) tick();
        chk("tx_hold_no_start", 128'(start_cnt - s0), 128'd0);
        busy_hold = 1'b0;
        wait_tx_done("tx_hold");

        // Random RX traffic against a queue model, concurrent with random TX blocks.
        busy_rand = 1'b1;
        m_hold = 1'b0; m_ovr = 0; o0 = ovr_cnt;
        fork
            begin
                for (int c = 0; c < 600; c++) begin
                    rx_valid      = ($urandom_range(0, 2) == 0);
                    rx_data       = 8'($urandom);
                    blk_out_ready = $urandom_range(0, 1) == 1;
                    if (m_hold) begin
                        if (rx_valid) m_ovr++;
                        if (blk_out_ready) m_hold = 1'b0;
                    end else if (rx_valid) begin
                        m_q.push_back(rx_data);
                        if (m_q.size() == 16) begin
                            for (int i = 0; i < 16; i++) m_blk[127-8*i -: 8] = m_q[i];
                            m_q.delete();
                            m_hold = 1'b1;
                        end
                    end
                    tick();
                    chk("rnd_valid", {127'd0, blk_out_valid}, {127'd0, m_hold});
                    if (m_hold) chk("rnd_blk", blk_out, m_blk);
                end
                rx_valid = 1'b0;
                blk_out_ready = 1'b0;
            end
            begin
                for (int b = 0; b < 3; b++)
                    offer_tx({$urandom, $urandom, $urandom, $urandom});
            end
        join
        tick(); tick();
        chk("rnd_overrun_total", 128'(ovr_cnt - o0), 128'(m_ovr));
        wait_tx_done("tx_rnd");
        busy_rand = 1'b0;
        if (m_hold || m_q.size() != 0) begin
            for (int i = int'(m_q.size()); i < 16; i++) send_byte(8'h00, 0);
            blk_out_ready = 1'b1;
            tick();
            blk_out_ready = 1'b0;
        end

        // Reset in the middle of both paths.
        send_seq(8'h70, 8'h01, 7);
        s0 = start_cnt;
        offer_tx(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        for (int i = 0; i < 200 && (start_cnt - s0) < 3; i++) tick();
        chk("mid_tx_started", 128'(start_cnt - s0), 128'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", {127'd0, blk_in_ready}, 128'd0);
        chk("mid_rst_blk_out", blk_out, 128'd0);
        chk("mid_rst_valid", {127'd0, blk_out_valid}, 128'd0);
        chk("mid_rst_tx_start", {127'd0, tx_start}, 128'd0);
        chk("mid_rst_tx_data", {120'd0, tx_data}, 128'd0);
        tick();
        rst = 1'b0;
        got_q.delete(); exp_q.delete();
        s0 = start_cnt;
        repeat (40) tick();
        chk("mid_no_start_after_rst", 128'(start_cnt - s0), 128'd0);
        chk("mid_ready_after_rst", {127'd0, blk_in_ready}, 128'd1);
        send_seq(8'h40, 8'h01, 16);
        wait_blk("mid_clean", 128'h404142434445464748494A4B4C4D4E4F);
        release_blk("mid");

`ifdef UART_BRIDGE_TIMEOUT_EN
        o0 = tmo_cnt;
        send_seq(8'hE0, 8'h01, 5);
        repeat (120) tick();
        chk("timeout_pulse", 128'(tmo_cnt - o0), 128'd1);
        send_seq(8'h50, 8'h01, 16);
        wait_blk("timeout_clean", 128'h505152535455565758595A5B5C5D5E5F);
        release_blk("timeout");
`else
        send_seq(8'hE0, 8'h01, 5);
        repeat (200) tick();
        chk("no_timeout_pulse", 128'(tmo_cnt), 128'd0);
        send_seq(8'h50, 8'h01, 11);
        wait_blk("no_timeout_keep", 128'hE0E1E2E3E4505152535455565758595A);
        release_blk("no_timeout");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
